// File: rtl/mult_ctrl_taint_if.sv
// Handshake and strobe bundle between a shift-add multiplier controller and its
// requester/datapath. The controller connects through the slave modport.
interface mult_ctrl_taint_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             start_t;
  logic [WIDTH-1:0] mr_bits;
  logic [WIDTH-1:0] mr_bits_t;
  logic             mrld;
  logic             mdld;
  logic             rsclear;
  logic             rsload;
  logic             rsshr;
  logic             mrld_t;
  logic             mdld_t;
  logic             rsclear_t;
  logic             rsload_t;
  logic             rsshr_t;
  logic             busy;
  logic             done;
  logic             done_t;

  modport master (
    output start, start_t, mr_bits, mr_bits_t,
    input  mrld, mdld, rsclear, rsload, rsshr,
    input  mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
    input  busy, done, done_t
  );

  modport slave (
    input  start, start_t, mr_bits, mr_bits_t,
    output mrld, mdld, rsclear, rsload, rsshr,
    output mrld_t, mdld_t, rsclear_t, rsload_t, rsshr_t,
    output busy, done, done_t
  );
endinterface

// File: rtl/mult_ctrl_taint.sv
// Shift-add multiplier control FSM with taint propagation on every strobe.
// Optional MULT_CTRL_STICKY_TAINT_EN makes per-iteration taint sticky for the whole operation.
module mult_ctrl_taint #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_ctrl_taint_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, INIT, TEST, ADD, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             st_t;
  logic             dec_t;
  logic             acc_t;
  logic             iter_t;
  logic             init_s;
  logic             load_s;
  logic             shr_s;
  logic             done_s;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      st_t  <= 1'b0;
      dec_t <= 1'b0;
      acc_t <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (bus.start) st_t <= bus.start_t;
        INIT: begin
          cnt   <= '0;
          acc_t <= 1'b0;
        end
        TEST: begin
          dec_t <= bus.mr_bits_t[cnt];
          acc_t <= acc_t | bus.mr_bits_t[cnt];
        end
        // The counter saturates on the last bit so it never wraps mid-operation.
        SHIFT: if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    init_s    = 1'b0;
    load_s    = 1'b0;
    shr_s     = 1'b0;
    done_s    = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = INIT;
      INIT: begin
        init_s    = 1'b1;
        state_nxt = TEST;
      end
      TEST:  state_nxt = bus.mr_bits[cnt] ? ADD : SHIFT;
      ADD: begin
        load_s    = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        shr_s     = 1'b1;
        state_nxt = (cnt == CNT_LAST) ? DONE : TEST;
      end
      DONE: begin
        done_s    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MULT_CTRL_STICKY_TAINT_EN
  // acc_t already contains dec_t; OR-ing it keeps both registers live in this build.
  assign iter_t = acc_t | dec_t;
`else
  assign iter_t = dec_t;
`endif

  assign bus.mrld      = init_s;
  assign bus.mdld      = init_s;
  assign bus.rsclear   = init_s;
  assign bus.rsload    = load_s;
  assign bus.rsshr     = shr_s;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_s;

  assign bus.mrld_t    = init_s & st_t;
  assign bus.mdld_t    = init_s & st_t;
  assign bus.rsclear_t = init_s & st_t;
  assign bus.rsload_t  = load_s & (st_t | iter_t);
  assign bus.rsshr_t   = shr_s  & (st_t | iter_t);
  assign bus.done_t    = done_s & (st_t | acc_t);
endmodule

// File: tb/tb_mult_ctrl_taint.sv
// Randomized bench for mult_ctrl_taint: a per-operation cycle trace is predicted
// from the multiply rules and compared against the DUT outputs every cycle.
module tb_mult_ctrl_taint;
  localparam int W = 4;
`ifdef MULT_CTRL_STICKY_TAINT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef logic [12:0] obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_ctrl_taint_if #(.WIDTH(W)) bus ();

  mult_ctrl_taint #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  obs_t       exp_q[$];
  int         since = 0;
  int         lat   = 0;
  logic [W-1:0] nxt_v, nxt_vt;
  logic       nxt_st;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic obs_t observe();
    return {bus.busy, bus.done, bus.done_t, bus.mrld, bus.mdld, bus.rsclear,
            bus.rsload, bus.rsshr, bus.mrld_t, bus.mdld_t, bus.rsclear_t,
            bus.rsload_t, bus.rsshr_t};
  endfunction

  // Expected output word for a busy cycle.
  function automatic obs_t word(bit dn, bit dn_t, bit ini, bit ini_t,
                                bit ld, bit ld_t, bit sh, bit sh_t);
    return {1'b1, dn, dn_t, ini, ini, ini, ld, sh, ini_t, ini_t, ini_t, ld_t, sh_t};
  endfunction

  // Predict the full cycle trace of one multiply from its operand and taints.
  task automatic plan(input logic [W-1:0] v, input logic [W-1:0] vt, input bit st);
    bit acc = 1'b0;
    bit tt;
    exp_q.push_back(word(0, 0, 1, st, 0, 0, 0, 0));
    for (int i = 0; i < W; i++) begin
      acc = acc | vt[i];
      tt  = st | (STICKY ? acc : vt[i]);
      exp_q.push_back(word(0, 0, 0, 0, 0, 0, 0, 0));
      if (v[i]) exp_q.push_back(word(0, 0, 0, 0, 1, tt, 0, 0));
      exp_q.push_back(word(0, 0, 0, 0, 0, 0, 1, tt));
    end
    exp_q.push_back(word(1, st | acc, 0, 0, 0, 0, 0, 0));
    lat = 2 + 2 * W + $countones(v);
  endtask

  // One clock cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic step(input bit want_start, input bit hold);
    obs_t e;
    bit   cur_idle;
    @(negedge clk);
    since++;
    cur_idle = (exp_q.size() == 0);
    e = cur_idle ? obs_t'(0) : exp_q.pop_front();
    check("trace", 32'(observe()), 32'(e));
    if (bus.done) check("latency", 32'(since), 32'(lat));
    if (cur_idle && want_start) begin
      bus.start     = 1'b1;
      bus.start_t   = nxt_st;
      bus.mr_bits   = nxt_v;
      bus.mr_bits_t = nxt_vt;
      plan(nxt_v, nxt_vt, nxt_st);
      since = 0;
    end else if (cur_idle) begin
      bus.start     = 1'b0;
      bus.start_t   = 1'($urandom);
      bus.mr_bits   = W'($urandom);
      bus.mr_bits_t = W'($urandom);
    end else begin
      // start is ignored while busy, so it is toggled freely here.
      bus.start   = hold ? 1'b1 : 1'($urandom);
      bus.start_t = 1'($urandom);
    end
  endtask

  task automatic run_op(input logic [W-1:0] v, input logic [W-1:0] vt, input bit st, input bit hold);
    nxt_v  = v;
    nxt_vt = vt;
    nxt_st = st;
    step(1'b1, hold);
    while (exp_q.size() > 0) step(1'b0, hold);
  endtask

  task automatic reset_mid_op();
    nxt_v  = 4'b0011;
    nxt_vt = '0;
    nxt_st = 1'b0;
    step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);  // INIT, TEST0, ADD0, SHIFT0, TEST1, ADD1
    #1 rst_n = 1'b0;
    #1 check("reset_async", 32'(observe()), 32'd0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("reset_hold", 32'(observe()), 32'd0);
    end
    rst_n         = 1'b1;
    bus.start     = 1'b1;
    bus.start_t   = 1'b0;
    bus.mr_bits   = 4'b0101;
    bus.mr_bits_t = 4'b0001;
    plan(4'b0101, 4'b0001, 1'b0);
    since = 0;
    while (exp_q.size() > 0) step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.start_t   = 1'b0;
    bus.mr_bits   = '0;
    bus.mr_bits_t = '0;
    #12 check("reset_state", 32'(observe()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 1'b0);
    run_op(4'b1011, 4'b0000, 1'b0, 1'b0);
    run_op(4'b0000, 4'b0000, 1'b0, 1'b0);
    run_op(4'b1111, 4'b0100, 1'b0, 1'b0);
    run_op(4'b0110, 4'b0000, 1'b1, 1'b0);
    // Back-to-back with start held high throughout.
    run_op(4'b1001, 4'b0010, 1'b0, 1'b1);
    run_op(4'b0111, 4'b0000, 1'b0, 1'b1);
    run_op(4'b1100, 4'b1000, 1'b1, 1'b1);
    reset_mid_op();

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    repeat (3) step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
